// File: rtl/rv_pkg.sv
// rv_pkg: shared constants and types for the RV32I fetch stage
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic {IDLE, RUN} fetch_state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [31:0]     instruction;
    logic            valid;
  } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; a bubble keeps pc fields and clears the instruction
module if_id_reg
  import rv_pkg::*;
(
  input  logic   clk,
  input  logic   rstN,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t data,
  output if_id_t q
);
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      q <= '{pc: '0, pc_plus4: '0, instruction: NOP_INSTR, valid: 1'b0};
    end else if (bubble) begin
      q.instruction <= NOP_INSTR;
      q.valid       <= 1'b0;
    end else if (load) begin
      q <= data;
    end
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: RV32I instruction fetch with start gating, stalls and redirects
module if_stage
  import rv_pkg::*;
#(
  parameter int                    PC_WIDTH          = 32,
  parameter int                    INSTRUCTION_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC          = '0
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         start,
  input  logic                         stall,
  input  logic                         redirect,
  input  logic [PC_WIDTH-1:0]          redirect_pc,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_instruction,
  output logic [PC_WIDTH-1:0]          id_pc,
  output logic [PC_WIDTH-1:0]          id_pc_plus4,
  output logic [INSTRUCTION_WIDTH-1:0] id_instruction,
  output logic                         id_valid,
  output logic                         misaligned
);
  fetch_state_t        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_plus4;
  logic                misaligned_q, misaligned_d;
  logic                load, bubble;
  if_id_t              if_id_q;
  assign pc_plus4  = pc_q + PC_WIDTH'(4);
  assign imem_addr = pc_q;
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end
  // redirect outranks stall so a taken branch is never lost behind a hazard
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    load         = 1'b0;
    bubble       = 1'b0;
    if (state_q == IDLE) begin
      bubble  = 1'b1;
      state_d = start ? RUN : IDLE;
    end else if (redirect) begin
      bubble       = 1'b1;
      pc_d         = {redirect_pc[PC_WIDTH-1:2], 2'b00};
      misaligned_d = misaligned_q | (|redirect_pc[1:0]);
    end else if (!stall) begin
      load = 1'b1;
      pc_d = pc_plus4;
    end
  end
  if_id_reg u_if_id (
    .clk    (clk),
    .rstN   (rstN),
    .load   (load),
    .bubble (bubble),
    .data   ('{pc: pc_q, pc_plus4: pc_plus4, instruction: imem_instruction, valid: 1'b1}),
    .q      (if_id_q)
  );
  assign id_pc          = if_id_q.pc;
  assign id_pc_plus4    = if_id_q.pc_plus4;
  assign id_instruction = if_id_q.instruction;
  assign id_valid       = if_id_q.valid;
  assign misaligned     = misaligned_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized and directed checks of if_stage against a behavioural fetch model
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 0, rstN = 1, start = 0, stall = 0, redirect = 0;
  logic [31:0] redirect_pc = 0;
  logic [31:0] imem_addr, imem_instruction, id_pc, id_pc_plus4, id_instruction;
  logic        id_valid, misaligned;
  int checks = 0, errors = 0;
  bit          m_run;
  logic [31:0] m_pc, m_idpc, m_idpc4, m_instr;
  logic        m_valid, m_mis;
  wire [129:0] obs = {imem_addr, id_pc, id_pc_plus4, id_instruction, id_valid, misaligned};
  wire [129:0] exp = {m_pc, m_idpc, m_idpc4, m_instr, m_valid, m_mis};

  if_stage dut (
    .clk(clk), .rstN(rstN), .start(start), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_instruction(imem_instruction),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_instruction(id_instruction),
    .id_valid(id_valid), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE13;
  endfunction
  assign imem_instruction = mem_f(imem_addr);

  task automatic model_reset();
    m_run = 0; m_pc = 0; m_idpc = 0; m_idpc4 = 0; m_instr = NOP; m_valid = 0; m_mis = 0;
  endtask

  // one clock edge: the model follows the fetch rules with the inputs held across the edge
  task automatic tick();
    @(posedge clk);
    if (!m_run) begin
      m_instr = NOP; m_valid = 0;
      if (start) m_run = 1;
    end else if (redirect) begin
      m_pc = redirect_pc & ~32'd3; m_instr = NOP; m_valid = 0;
      if (redirect_pc % 4 != 0) m_mis = 1;
    end else if (!stall) begin
      m_idpc = m_pc; m_idpc4 = m_pc + 32'd4; m_instr = mem_f(m_pc); m_valid = 1;
      m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  task automatic test_reset();
    #2 rstN = 0;
    model_reset();
    #1;
    checks++;
    if (obs !== exp || imem_addr !== 0 || id_instruction !== NOP || id_valid !== 0) begin
      errors++; $display("FAIL reset obs=%h exp=%h", obs, exp);
    end
    @(negedge clk) rstN = 1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      stall = 1'($urandom); redirect = 1'($urandom); redirect_pc = $urandom;
      tick();
      checks++;
      if (obs !== exp || imem_addr !== 0 || id_valid !== 0 || misaligned !== 0) begin
        errors++; $display("FAIL idle_ignore obs=%h exp=%h", obs, exp);
      end
    end
    stall = 0; redirect = 0;
  endtask

  task automatic test_startup();
    start = 1; tick(); start = 0;
    checks++;
    if (id_valid !== 0 || obs !== exp) begin errors++; $display("FAIL start_bubble obs=%h exp=%h", obs, exp); end
    tick();
    checks++;
    if (id_pc !== 0 || id_instruction !== 32'h0050_0093 || id_pc_plus4 !== 4 || id_valid !== 1 || obs !== exp) begin
      errors++; $display("FAIL first_fetch obs=%h exp=%h", obs, exp);
    end
    tick();
    checks++;
    if (id_pc !== 4 || id_instruction !== 32'h00A0_0113 || imem_addr !== 8 || obs !== exp) begin
      errors++; $display("FAIL second_fetch obs=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (imem_addr !== 8 || id_pc !== 4 || id_instruction !== 32'h00A0_0113 || id_valid !== 1 || obs !== exp) begin
        errors++; $display("FAIL stall_hold cycle %0d obs=%h exp=%h", i, obs, exp);
      end
    end
    stall = 0; tick();
    checks++;
    if (id_pc !== 8 || id_instruction !== mem_f(8) || imem_addr !== 32'hC || obs !== exp) begin
      errors++; $display("FAIL stall_release obs=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_redirect();
    tick();
    redirect = 1; redirect_pc = 32'h40; tick(); redirect = 0;
    checks++;
    if (imem_addr !== 32'h40 || id_valid !== 0 || id_instruction !== NOP || id_pc !== 32'hC || obs !== exp) begin
      errors++; $display("FAIL redirect_bubble obs=%h exp=%h", obs, exp);
    end
    tick();
    checks++;
    if (id_pc !== 32'h40 || id_valid !== 1 || id_pc_plus4 !== 32'h44 || obs !== exp) begin
      errors++; $display("FAIL redirect_target obs=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_redirect_stall();
    redirect = 1; stall = 1; redirect_pc = 32'h80; tick(); redirect = 0; stall = 0;
    checks++;
    if (imem_addr !== 32'h80 || id_valid !== 0 || id_instruction !== NOP || obs !== exp) begin
      errors++; $display("FAIL redirect_over_stall obs=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_misaligned();
    redirect = 1; redirect_pc = 32'h42; tick(); redirect = 0;
    checks++;
    if (imem_addr !== 32'h40 || misaligned !== 1 || obs !== exp) begin
      errors++; $display("FAIL misaligned_set obs=%h exp=%h", obs, exp);
    end
    tick();
    redirect = 1; redirect_pc = 32'h100; tick(); redirect = 0;
    checks++;
    if (imem_addr !== 32'h100 || misaligned !== 1 || obs !== exp) begin
      errors++; $display("FAIL misaligned_sticky obs=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_wrap_and_reset();
    redirect = 1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect = 0;
    tick();
    checks++;
    if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 0 || imem_addr !== 0 || obs !== exp) begin
      errors++; $display("FAIL pc_wrap obs=%h exp=%h", obs, exp);
    end
    #3 rstN = 0;
    model_reset();
    #1;
    checks++;
    if (imem_addr !== 0 || id_pc !== 0 || id_pc_plus4 !== 0 || id_instruction !== NOP ||
        id_valid !== 0 || misaligned !== 0 || obs !== exp) begin
      errors++; $display("FAIL async_reset obs=%h exp=%h", obs, exp);
    end
    @(negedge clk) rstN = 1;
  endtask

  task automatic test_random();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 400; i++) begin
      start       = ($urandom_range(0, 9) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 6) == 0);
      redirect_pc = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & ~32'd3);
      tick();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL random cycle %0d obs=%h exp=%h", i, obs, exp); end
      if ($urandom_range(0, 99) == 0) begin
        rstN = 0; model_reset(); #1;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL random_reset cycle %0d obs=%h exp=%h", i, obs, exp); end
        rstN = 1;
      end
    end
    start = 0; stall = 0; redirect = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_startup();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_misaligned();
    test_wrap_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
